// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and helpers for the LED matrix scanner.
//   scan_state_e : BLANK / ON phase of a row slot
//   slot_len     : cycles per row slot (blanking + PWM period)
//   frame_len    : cycles per full frame
//   active_level : maps a logical "on" bit onto the physical pin level
package led_matrix_scanner_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    function automatic int unsigned slot_len(input int unsigned blank_cycles,
                                             input int unsigned bright_bits);
        return blank_cycles + (32'd1 << bright_bits);
    endfunction

    function automatic int unsigned frame_len(input int unsigned rows,
                                              input int unsigned blank_cycles,
                                              input int unsigned bright_bits);
        return rows * slot_len(blank_cycles, bright_bits);
    endfunction

    // Active-low drivers invert the logical value.
    function automatic logic active_level(input logic active_low, input logic value);
        return value ^ active_low;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_slot_counter.sv
// Row index / slot position counters for the LED matrix scanner.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : 0 clears both counters on the next edge
//   row_idx      : row currently being scanned
//   k            : position inside the row slot, 0..SLOT-1
//   snap_c       : first cycle of row 0 (frame snapshot point)
//   blank_last_c : last blanking cycle of the slot
//   slot_last_c  : last cycle of the slot
module led_matrix_scanner_scan_slot_counter #(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned SLOT         = 9,
    parameter int unsigned BLANK_CYCLES = 1,
    localparam int unsigned RW          = $clog2(ROWS),
    localparam int unsigned KW          = $clog2(SLOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [RW-1:0] row_idx,
    output logic [KW-1:0] k,
    output logic          snap_c,
    output logic          blank_last_c,
    output logic          slot_last_c
);

    logic row_last_c;

    assign slot_last_c  = (k == KW'(SLOT - 1));
    assign blank_last_c = (k == KW'(BLANK_CYCLES - 1));
    assign row_last_c   = (row_idx == RW'(ROWS - 1));
    assign snap_c       = (row_idx == '0) && (k == '0);

    // Slot position wraps into the next row; the row index wraps per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx <= '0;
            k       <= '0;
        end else if (!enable) begin
            row_idx <= '0;
            k       <= '0;
        end else if (slot_last_c) begin
            k       <= '0;
            row_idx <= row_last_c ? '0 : row_idx + RW'(1);
        end else begin
            k <= k + KW'(1);
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Multiplexed ROWS x COLS LED matrix scanner with per-row PWM and blanking.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : scan enable; 0 blanks the display and restarts the frame
//   pixels      : pixel bit for row r, column c at index r*COLS+c
//   brightness  : lit cycles per row slot (0 = dark)
//   row_out     : row drivers, one-hot active during the ON phase
//   col_out     : column drivers
//   frame_start : one-cycle pulse marking the snapshot cycle
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned BRIGHT_BITS    = 3,
    parameter int unsigned BLANK_CYCLES   = 1,
    parameter int unsigned ROW_ACTIVE_LOW = 1,
    parameter int unsigned COL_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [ROWS*COLS-1:0]   pixels,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [ROWS-1:0]        row_out,
    output logic [COLS-1:0]        col_out,
    output logic                   frame_start
);

    localparam int unsigned SLOT  = slot_len(BLANK_CYCLES, BRIGHT_BITS);
    localparam int unsigned PIX_W = ROWS * COLS;
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned KW    = $clog2(SLOT);

    localparam logic            ROW_AL   = (ROW_ACTIVE_LOW != 0);
    localparam logic            COL_AL   = (COL_ACTIVE_LOW != 0);
    localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{ROW_AL}};
    localparam logic [COLS-1:0] COL_IDLE = {COLS{COL_AL}};

    scan_state_e            state_q, state_d;
    logic [PIX_W-1:0]       shadow_pix;
    logic [BRIGHT_BITS-1:0] shadow_bright;
    logic [RW-1:0]          row_idx;
    logic [KW-1:0]          k;
    logic                   snap_c, blank_last_c, slot_last_c;
    logic                   snap_take_c;
    logic [KW-1:0]          phase;
    logic [COLS-1:0]        cur_pix;
    logic [ROWS-1:0]        row_d;
    logic [COLS-1:0]        col_d;
    logic                   frame_start_d;
    logic [COLS-1:0]        pix_rows [ROWS];

    led_matrix_scanner_scan_slot_counter #(
        .ROWS         (ROWS),
        .SLOT         (SLOT),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .row_idx      (row_idx),
        .k            (k),
        .snap_c       (snap_c),
        .blank_last_c (blank_last_c),
        .slot_last_c  (slot_last_c)
    );

    // Per-row view of the pixel shadow.
    for (genvar g = 0; g < int'(ROWS); g++) begin : g_rows
        assign pix_rows[g] = shadow_pix[g*COLS +: COLS];
    end

    assign cur_pix     = pix_rows[row_idx];
    assign snap_take_c = enable && snap_c;

    // Next-state and next-output decode.
    always_comb begin
        state_d       = state_q;
        row_d         = ROW_IDLE;
        col_d         = COL_IDLE;
        frame_start_d = 1'b0;
        phase         = k - KW'(BLANK_CYCLES);
        if (!enable) begin
            state_d = ST_BLANK;
        end else begin
            frame_start_d = snap_c;
            case (state_q)
                ST_BLANK: begin
                    if (blank_last_c) state_d = ST_ON;
                end
                ST_ON: begin
                    if (slot_last_c) state_d = ST_BLANK;
                    for (int r = 0; r < int'(ROWS); r++) begin
                        row_d[r] = active_level(ROW_AL, RW'(r) == row_idx);
                    end
                    // Row stays driven for the whole ON phase; PWM gates only the columns.
                    for (int c = 0; c < int'(COLS); c++) begin
                        col_d[c] = active_level(COL_AL,
                                                cur_pix[c] && (phase < KW'(shadow_bright)));
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // State, output and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            row_out       <= ROW_IDLE;
            col_out       <= COL_IDLE;
            frame_start   <= 1'b0;
            shadow_pix    <= '0;
            shadow_bright <= '0;
        end else begin
            state_q     <= state_d;
            row_out     <= row_d;
            col_out     <= col_d;
            frame_start <= frame_start_d;
            if (snap_take_c) begin
                shadow_pix    <= pixels;
                shadow_bright <= brightness;
            end
        end
    end

endmodule
